// File: rtl/fetch_sequencer.sv
// Instruction fetch stage with CALL/RET/RTI/interrupt micro-sequencer and load-use bubbles.
// Optional INT_VECTOR_EN adds an int_vec input that replaces the fixed INT_VEC handler address.
module fetch_sequencer #(
  parameter int unsigned IW        = 16,
  parameter int unsigned AW        = 6,
  parameter int unsigned PCW       = 32,
  parameter int unsigned RESET_VEC = 31,
  parameter int unsigned INT_VEC   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             prog_we,
  input  logic [AW-1:0]    prog_addr,
  input  logic [IW-1:0]    prog_data,
  input  logic             jump_valid,
  input  logic [PCW-1:0]   jump_target,
  input  logic             int_req,
`ifdef INT_VECTOR_EN
  input  logic [PCW-1:0]   int_vec,
`endif
  input  logic             pop_rvalid,
  input  logic [PCW/2-1:0] pop_rdata,
  output logic [IW-1:0]    instr_out,
  output logic             instr_valid,
  output logic             push_valid,
  output logic [PCW/2-1:0] push_data,
  output logic             int_ack,
  output logic             rti_done,
  output logic             busy
);
  localparam int unsigned HW = PCW / 2;

  localparam logic [4:0] OP_PUSH = 5'd8;
  localparam logic [4:0] OP_LDA  = 5'd9;
  localparam logic [4:0] OP_LDB  = 5'd10;
  localparam logic [4:0] OP_POP  = 5'd11;
  localparam logic [4:0] OP_CALL = 5'd20;
  localparam logic [4:0] OP_RET  = 5'd21;
  localparam logic [4:0] OP_RTI  = 5'd22;

  typedef enum logic [2:0] {
    S_RUN, S_INT_HI, S_INT_LO, S_CALL_LO, S_POP_LO, S_POP_HI, S_RESUME
  } state_t;

  state_t          state, state_nx;
  logic [PCW-1:0]  pc, pc_nx;
  logic            rti_q, rti_nx;
  logic [IW-1:0]   instr_nx;
  logic            ivalid_nx, pv_nx, ack_nx, rdone_nx;
  logic [HW-1:0]   pd_nx;

  logic [IW-1:0]   mem [0:(1<<AW)-1];
  logic [PCW-1:0]  vec, seq_pc, fetch_addr;
  logic [IW-1:0]   fetched;
  logic [4:0]      f_op, l_op;
  logic [2:0]      ld_dest;
  logic            hazard, do_fetch;

`ifdef INT_VECTOR_EN
  assign vec = int_vec;
`else
  assign vec = PCW'(INT_VEC);
`endif

  assign busy = (state != S_RUN);

  always_ff @(posedge clk) begin
    if (!rst && prog_we) mem[prog_addr] <= prog_data;
  end

  always_comb begin
    state_nx  = state;
    pc_nx     = pc;
    rti_nx    = rti_q;
    instr_nx  = '0;
    ivalid_nx = 1'b0;
    pv_nx     = 1'b0;
    pd_nx     = '0;
    ack_nx    = 1'b0;
    rdone_nx  = 1'b0;
    do_fetch  = 1'b0;

    seq_pc = jump_valid ? jump_target : pc + PCW'(1);
    case (state)
      S_INT_LO: fetch_addr = vec;
      S_RESUME: fetch_addr = pc;
      default:  fetch_addr = seq_pc;
    endcase
    fetched = mem[fetch_addr[AW-1:0]];
    f_op    = fetched[IW-1:IW-5];

    // Load-use check compares against what is currently on instr_out
    l_op    = instr_out[IW-1:IW-5];
    ld_dest = (l_op == OP_LDB) ? instr_out[7:5] : instr_out[10:8];
    hazard  = ((l_op == OP_LDA) || (l_op == OP_LDB)) &&
              ((fetched[10:8] == ld_dest) || (fetched[7:5] == ld_dest));

    if (!prog_we) begin
      case (state)
        S_RUN: begin
          if (int_req) begin
            state_nx  = S_INT_HI;
            instr_nx  = {OP_PUSH, {(IW-5){1'b0}}};
            ivalid_nx = 1'b1;
            pv_nx     = 1'b1;
            pd_nx     = pc[PCW-1:HW];
          end else if (!(hazard && !jump_valid)) begin
            do_fetch = 1'b1;
          end
        end
        S_INT_HI: begin
          state_nx  = S_INT_LO;
          instr_nx  = {OP_PUSH, {(IW-5){1'b0}}};
          ivalid_nx = 1'b1;
          pv_nx     = 1'b1;
          pd_nx     = pc[HW-1:0];
          ack_nx    = 1'b1;
        end
        S_INT_LO: begin
          state_nx = S_RUN;
          do_fetch = 1'b1;
        end
        S_CALL_LO: begin
          state_nx = S_RUN;
          pv_nx    = 1'b1;
          pd_nx    = pc[HW-1:0];
        end
        S_POP_LO: begin
          if (pop_rvalid) begin
            pc_nx[HW-1:0] = pop_rdata;
            state_nx      = S_POP_HI;
          end
        end
        S_POP_HI: begin
          if (pop_rvalid) begin
            pc_nx[PCW-1:HW] = pop_rdata;
            state_nx        = S_RESUME;
            rdone_nx        = rti_q;
          end
        end
        S_RESUME: begin
          state_nx = S_RUN;
          do_fetch = 1'b1;
        end
        default: state_nx = S_RUN;
      endcase
    end

    // Every fetch path (run, interrupt vector, resume) decodes CALL/RET/RTI the same way
    if (do_fetch) begin
      pc_nx     = fetch_addr;
      ivalid_nx = 1'b1;
      case (f_op)
        OP_CALL: begin
          instr_nx = {OP_PUSH, fetched[IW-6:0]};
          pv_nx    = 1'b1;
          pd_nx    = fetch_addr[PCW-1:HW];
          state_nx = S_CALL_LO;
        end
        OP_RET, OP_RTI: begin
          instr_nx = {OP_POP, fetched[IW-6:0]};
          rti_nx   = (f_op == OP_RTI);
          state_nx = S_POP_LO;
        end
        default: instr_nx = fetched;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RUN;
      pc          <= PCW'(RESET_VEC);
      rti_q       <= 1'b0;
      instr_out   <= '0;
      instr_valid <= 1'b0;
      push_valid  <= 1'b0;
      push_data   <= '0;
      int_ack     <= 1'b0;
      rti_done    <= 1'b0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      rti_q       <= rti_nx;
      instr_out   <= instr_nx;
      instr_valid <= ivalid_nx;
      push_valid  <= pv_nx;
      push_data   <= pd_nx;
      int_ack     <= ack_nx;
      rti_done    <= rdone_nx;
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: table-driven fetch/hazard vectors plus hand sequences.
module tb_fetch_sequencer;
  localparam int unsigned IW = 16, AW = 6, PCW = 32, HW = 16;

  logic           clk = 1'b0;
  logic           rst, prog_we, jump_valid, int_req, pop_rvalid;
  logic [AW-1:0]  prog_addr;
  logic [IW-1:0]  prog_data;
  logic [PCW-1:0] jump_target;
  logic [HW-1:0]  pop_rdata;
  logic [IW-1:0]  instr_out;
  logic           instr_valid, push_valid, int_ack, rti_done, busy;
  logic [HW-1:0]  push_data;
`ifdef INT_VECTOR_EN
  logic [PCW-1:0] int_vec = '0;
`endif

  fetch_sequencer #(
    .IW(IW), .AW(AW), .PCW(PCW), .RESET_VEC(31), .INT_VEC(0)
  ) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .jump_valid(jump_valid), .jump_target(jump_target), .int_req(int_req),
`ifdef INT_VECTOR_EN
    .int_vec(int_vec),
`endif
    .pop_rvalid(pop_rvalid), .pop_rdata(pop_rdata), .instr_out(instr_out),
    .instr_valid(instr_valid), .push_valid(push_valid), .push_data(push_data),
    .int_ack(int_ack), .rti_done(rti_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] instr;
    logic        iv;
    logic        pv;
    logic [15:0] pd;
    logic        ack;
    logic        rdn;
    logic        bsy;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    logic        jv;
    logic [31:0] jt;
    exp_t        e;
  } vec_t;

  exp_t        sb[$];
  int unsigned n_total = 0, n_pass = 0;
  logic [15:0] mm [64];
  vec_t        tbl [15];

  function automatic exp_t ex(input logic [15:0] instr, input logic iv, input logic pv,
                              input logic [15:0] pd, input logic ack, input logic rdn,
                              input logic bsy, input logic [31:0] pcv);
    return {instr, iv, pv, pd, ack, rdn, bsy, pcv};
  endfunction

  function automatic exp_t bub(input logic bsy, input logic [31:0] pcv);
    return ex(16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, bsy, pcv);
  endfunction

  function automatic exp_t run_ex(input logic [15:0] instr, input logic [31:0] pcv);
    return ex(instr, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, pcv);
  endfunction

  function automatic vec_t mkv(input logic jv, input logic [31:0] jt, input exp_t e);
    vec_t v;
    v.jv = jv;
    v.jt = jt;
    v.e  = e;
    return v;
  endfunction

  task automatic step(input string nm, input logic r, input logic we, input logic [5:0] wa,
                      input logic [15:0] wd, input logic jv, input logic [31:0] jt,
                      input logic ir, input logic rv, input logic [15:0] rd, input exp_t e);
    exp_t want, got;
    rst = r; prog_we = we; prog_addr = wa; prog_data = wd;
    jump_valid = jv; jump_target = jt; int_req = ir; pop_rvalid = rv; pop_rdata = rd;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got  = {instr_out, instr_valid, push_valid, push_data, int_ack, rti_done, busy, dut.pc};
    want = sb.pop_front();
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got instr=%h iv=%b pv=%b pd=%h ack=%b rti=%b busy=%b pc=%h; expected instr=%h iv=%b pv=%b pd=%h ack=%b rti=%b busy=%b pc=%h",
                  nm, got.instr, got.iv, got.pv, got.pd, got.ack, got.rdn, got.bsy, got.pc,
                  want.instr, want.iv, want.pv, want.pd, want.ack, want.rdn, want.bsy, want.pc);
  endtask

  task automatic run(input string nm, input logic jv, input logic [31:0] jt, input logic ir,
                     input logic rv, input logic [15:0] rd, input exp_t e);
    step(nm, 1'b0, 1'b0, 6'd0, 16'h0, jv, jt, ir, rv, rd, e);
  endtask

  initial begin
    for (int a = 0; a < 64; a++) mm[a] = 16'h0800 | 16'(a);
    mm[0]  = 16'h3001;  mm[6]  = 16'hA803;  mm[7]  = 16'h1234;  mm[9]  = 16'h2222;
    mm[12] = 16'h1B0C;  mm[32] = 16'h1000;  mm[33] = 16'h2000;  mm[40] = 16'h5060;
    mm[41] = 16'h1301;  mm[44] = 16'h4D00;  mm[45] = 16'h10A0;  mm[46] = 16'h5060;
    mm[50] = 16'hA0AB;  mm[52] = 16'hB005;

    tbl[0]  = mkv(1'b0, 32'd0,        run_ex(16'h1000, 32'd32));
    tbl[1]  = mkv(1'b0, 32'd0,        run_ex(16'h2000, 32'd33));
    tbl[2]  = mkv(1'b1, 32'd40,       run_ex(16'h5060, 32'd40));
    tbl[3]  = mkv(1'b0, 32'd0,        bub(1'b0, 32'd40));
    tbl[4]  = mkv(1'b0, 32'd0,        run_ex(16'h1301, 32'd41));
    tbl[5]  = mkv(1'b1, 32'd40,       run_ex(16'h5060, 32'd40));
    tbl[6]  = mkv(1'b1, 32'd12,       run_ex(16'h1B0C, 32'd12));
    tbl[7]  = mkv(1'b0, 32'd0,        run_ex(16'h080D, 32'd13));
    tbl[8]  = mkv(1'b1, 32'd44,       run_ex(16'h4D00, 32'd44));
    tbl[9]  = mkv(1'b0, 32'd0,        bub(1'b0, 32'd44));
    tbl[10] = mkv(1'b0, 32'd0,        run_ex(16'h10A0, 32'd45));
    tbl[11] = mkv(1'b0, 32'd0,        run_ex(16'h5060, 32'd46));
    tbl[12] = mkv(1'b0, 32'd0,        run_ex(16'h082F, 32'd47));
    tbl[13] = mkv(1'b1, 32'hFFFFFFFF, run_ex(16'h083F, 32'hFFFFFFFF));
    tbl[14] = mkv(1'b0, 32'd0,        run_ex(16'h3001, 32'd0));

    step("reset0", 1'b1, 1'b0, 6'd0, 16'h0, 1'b0, 32'd0, 1'b0, 1'b0, 16'h0, bub(1'b0, 32'd31));
    step("reset1", 1'b1, 1'b0, 6'd0, 16'h0, 1'b1, 32'd9, 1'b1, 1'b0, 16'h0, bub(1'b0, 32'd31));
    for (int a = 0; a < 64; a++)
      step($sformatf("load%0d", a), 1'b0, 1'b1, 6'(a), mm[a], 1'b0, 32'd0, 1'b0, 1'b0, 16'h0,
           bub(1'b0, 32'd31));

    for (int i = 0; i < 15; i++)
      run($sformatf("vec%0d", i), tbl[i].jv, tbl[i].jt, 1'b0, 1'b0, 16'h0, tbl[i].e);

    // interrupt entry from pc 0x0001_0005
    run("int_setup", 1'b1, 32'h0001_0005, 1'b0, 1'b0, 16'h0, run_ex(16'h0805, 32'h0001_0005));
    run("int_hi",    1'b0, 32'd0,  1'b1, 1'b0, 16'h0,
        ex(16'h4000, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 32'h0001_0005));
    run("int_lo",    1'b1, 32'd20, 1'b1, 1'b0, 16'h0,
        ex(16'h4000, 1'b1, 1'b1, 16'h0005, 1'b1, 1'b0, 1'b1, 32'h0001_0005));
    run("int_vec",   1'b1, 32'd20, 1'b0, 1'b0, 16'h0, run_ex(16'h3001, 32'd0));
    run("int_next",  1'b0, 32'd0,  1'b0, 1'b0, 16'h0, run_ex(16'h0801, 32'd1));

    // RET with late pops
    run("ret_op",    1'b1, 32'd6,  1'b0, 1'b0, 16'h0,
        ex(16'h5803, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 32'd6));
    run("ret_w0",    1'b0, 32'd0,  1'b0, 1'b0, 16'h0, bub(1'b1, 32'd6));
    run("ret_w1",    1'b1, 32'd20, 1'b0, 1'b0, 16'h0, bub(1'b1, 32'd6));
    run("ret_w2",    1'b0, 32'd0,  1'b0, 1'b0, 16'h0, bub(1'b1, 32'd6));
    run("ret_lo",    1'b0, 32'd0,  1'b0, 1'b1, 16'h0007, bub(1'b1, 32'd7));
    run("ret_w3",    1'b0, 32'd0,  1'b0, 1'b0, 16'h0, bub(1'b1, 32'd7));
    run("ret_hi",    1'b0, 32'd0,  1'b0, 1'b1, 16'h0000, bub(1'b1, 32'd7));
    run("ret_res",   1'b0, 32'd0,  1'b0, 1'b0, 16'h0, run_ex(16'h1234, 32'd7));
    run("ret_next",  1'b0, 32'd0,  1'b0, 1'b0, 16'h0, run_ex(16'h0808, 32'd8));

    // RTI restoring a non-zero high half
    run("rti_op",    1'b1, 32'd52, 1'b0, 1'b0, 16'h0,
        ex(16'h5805, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 32'd52));
    run("rti_lo",    1'b0, 32'd0,  1'b0, 1'b1, 16'h0009, bub(1'b1, 32'd9));
    run("rti_hi",    1'b0, 32'd0,  1'b0, 1'b1, 16'h0001,
        ex(16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 32'h0001_0009));
    run("rti_res",   1'b0, 32'd0,  1'b0, 1'b0, 16'h0, run_ex(16'h2222, 32'h0001_0009));
    run("rti_next",  1'b0, 32'd0,  1'b0, 1'b0, 16'h0, run_ex(16'h080A, 32'h0001_000A));

    // CALL from 0x0002_0032
    run("call_hi",   1'b1, 32'h0002_0032, 1'b0, 1'b0, 16'h0,
        ex(16'h40AB, 1'b1, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b1, 32'h0002_0032));
    run("call_lo",   1'b1, 32'd3, 1'b0, 1'b0, 16'h0,
        ex(16'h0, 1'b0, 1'b1, 16'h0032, 1'b0, 1'b0, 1'b0, 32'h0002_0032));
    run("call_tgt",  1'b1, 32'd3, 1'b0, 1'b0, 16'h0, run_ex(16'h0803, 32'd3));

    // reset while waiting in POP_HI, then program-load freeze
    run("rst_ret",   1'b1, 32'd6, 1'b0, 1'b0, 16'h0,
        ex(16'h5803, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 32'd6));
    run("rst_lo",    1'b0, 32'd0, 1'b0, 1'b1, 16'h0004, bub(1'b1, 32'd4));
    step("rst_pophi", 1'b1, 1'b0, 6'd0, 16'h0, 1'b0, 32'd0, 1'b0, 1'b1, 16'h00FF, bub(1'b0, 32'd31));
    run("rst_run",   1'b0, 32'd0, 1'b0, 1'b0, 16'h0, run_ex(16'h1000, 32'd32));
    step("freeze", 1'b0, 1'b1, 6'd33, 16'h2000, 1'b1, 32'd5, 1'b0, 1'b0, 16'h0, bub(1'b0, 32'd32));
    run("unfreeze",  1'b0, 32'd0, 1'b0, 1'b0, 16'h0, run_ex(16'h2000, 32'd33));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
